// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings and memtest master state/pattern constants.
package peripheral_ahb3_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HWORD = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_DRAIN,
    ST_RD,
    ST_RD_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [31:0] PAT_MULT  = 32'h9E37_79B9;
  localparam logic [3:0]  HPROT_VAL = 4'b0011;

endpackage

// File: rtl/peripheral_ahb3_memtest_master_if.sv
// AHB3-Lite bus bundle between the memtest master and its RAM slave.
interface peripheral_ahb3_memtest_master_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/peripheral_ahb3_memtest_pattern.sv
// Combinational test pattern: the 32-bit word SEED ^ (idx * PAT_MULT) replicated to XLEN.
module peripheral_ahb3_memtest_pattern
  import peripheral_ahb3_pkg::*;
#(
  parameter int          XLEN = 64,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic [31:0]     idx_i,
  output logic [XLEN-1:0] pat_o
);
  logic [31:0] word;

  assign word  = SEED ^ (idx_i * PAT_MULT);
  assign pat_o = {(XLEN/32){word}};
endmodule

// File: rtl/peripheral_ahb3_memtest_master.sv
// AHB3-Lite memtest master: INCR-burst write of a pattern, read-back and compare.
// Optional macro PERIPHERAL_AHB3_MEMTEST_STOP_ON_ERROR_EN stops issuing beats after the first error.
module peripheral_ahb3_memtest_master
  import peripheral_ahb3_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              PLEN      = 64,
  parameter logic [PLEN-1:0] BASE_ADDR = '0,
  parameter int              NUM_WORDS = 256,
  parameter logic [31:0]     SEED      = 32'h0000_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  peripheral_ahb3_memtest_master_if.master ahb
);

  localparam logic [31:0]     LAST_IDX  = 32'(NUM_WORDS - 1);
  localparam logic [PLEN-1:0] ADDR_STEP = PLEN'(XLEN / 8);

  state_e          state_q, state_d;
  htrans_e         htrans_q, htrans_d;
  logic [PLEN-1:0] haddr_q, haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [31:0]     addrIdx_q, addrIdx_d;
  logic            dataActive_q, dataActive_d;
  logic            dataWrite_q, dataWrite_d;
  logic [31:0]     dataIdx_q, dataIdx_d;
  logic            errSeen_q, errSeen_d;
  logic [15:0]     errCnt_q, errCnt_d;

  logic [XLEN-1:0] patWord;
  logic            startAccept;
  logic            respErr;
  logic            mismatch;
  logic            errInc;
  logic            stopReq;

  peripheral_ahb3_memtest_pattern #(
    .XLEN (XLEN),
    .SEED (SEED)
  ) u_pattern (
    .idx_i (dataIdx_q),
    .pat_o (patWord)
  );

  assign startAccept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // An ERROR is counted on its first (HREADY=0) cycle; its closing cycle skips the compare.
  assign respErr  = dataActive_q && ahb.HRESP && !ahb.HREADY && !errSeen_q;
  assign mismatch = dataActive_q && !dataWrite_q && ahb.HREADY && !ahb.HRESP &&
                    !errSeen_q && (ahb.HRDATA != patWord);
  assign errInc   = respErr || mismatch;

`ifdef PERIPHERAL_AHB3_MEMTEST_STOP_ON_ERROR_EN
  logic stop_q, stop_d;

  assign stop_d  = startAccept ? 1'b0 : (stop_q || errInc);
  assign stopReq = stop_q || errInc;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) stop_q <= 1'b0;
    else          stop_q <= stop_d;
  end
`else
  assign stopReq = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    htrans_d  = htrans_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    addrIdx_d = addrIdx_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WR;
          htrans_d  = HTRANS_NONSEQ;
          haddr_d   = BASE_ADDR;
          hwrite_d  = 1'b1;
          addrIdx_d = '0;
        end
      end
      ST_WR, ST_RD: begin
        if (ahb.HREADY) begin
          if ((addrIdx_q == LAST_IDX) || stopReq) begin
            state_d  = (state_q == ST_WR) ? ST_WR_DRAIN : ST_RD_DRAIN;
            htrans_d = HTRANS_IDLE;
          end else begin
            htrans_d  = HTRANS_SEQ;
            haddr_d   = haddr_q + ADDR_STEP;
            addrIdx_d = addrIdx_q + 32'd1;
          end
        end
      end
      ST_WR_DRAIN: begin
        if (ahb.HREADY) begin
          if (stopReq) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RD;
            htrans_d  = HTRANS_NONSEQ;
            haddr_d   = BASE_ADDR;
            hwrite_d  = 1'b0;
            addrIdx_d = '0;
          end
        end
      end
      ST_RD_DRAIN: begin
        if (ahb.HREADY) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data-phase tracker: an accepted address phase becomes the next data phase.
  always_comb begin
    dataActive_d = dataActive_q;
    dataWrite_d  = dataWrite_q;
    dataIdx_d    = dataIdx_q;
    errSeen_d    = errSeen_q || respErr;
    if (ahb.HREADY) begin
      dataActive_d = (htrans_q != HTRANS_IDLE);
      dataWrite_d  = hwrite_q;
      dataIdx_d    = addrIdx_q;
      errSeen_d    = 1'b0;
    end
  end

  always_comb begin
    errCnt_d = errCnt_q;
    if (startAccept)                          errCnt_d = '0;
    else if (errInc && (errCnt_q != 16'hFFFF)) errCnt_d = errCnt_q + 16'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= BASE_ADDR;
      hwrite_q     <= 1'b0;
      addrIdx_q    <= '0;
      dataActive_q <= 1'b0;
      dataWrite_q  <= 1'b0;
      dataIdx_q    <= '0;
      errSeen_q    <= 1'b0;
      errCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      addrIdx_q    <= addrIdx_d;
      dataActive_q <= dataActive_d;
      dataWrite_q  <= dataWrite_d;
      dataIdx_q    <= dataIdx_d;
      errSeen_q    <= errSeen_d;
      errCnt_q     <= errCnt_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign pass    = done && (errCnt_q == 16'h0000);
  assign err_cnt = errCnt_q;

  assign ahb.HSEL      = (htrans_q != HTRANS_IDLE);
  assign ahb.HADDR     = haddr_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HWDATA    = (dataActive_q && dataWrite_q) ? patWord : '0;
  assign ahb.HSIZE     = (XLEN == 64) ? HSIZE_DWORD : HSIZE_WORD;
  assign ahb.HBURST    = HBURST_INCR;
  assign ahb.HPROT     = HPROT_VAL;
  assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_ahb3_memtest_master.sv
// Bench: plays a RAM slave with scripted wait states, ERROR responses and read corruption,
// and predicts err_cnt, the beat sequence and the RAM contents from those scripts.
`timescale 1ns/1ps
module tb_peripheral_ahb3_memtest_master;
  import peripheral_ahb3_pkg::*;

  localparam int              XLEN = 64;
  localparam int              PLEN = 64;
  localparam int              NW   = 4;
  localparam int              NB   = 2 * NW;
  localparam logic [PLEN-1:0] BASE = 64'h100;
  localparam logic [31:0]     SEED = 32'h0000_0001;
  localparam int              STEP = XLEN / 8;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_cnt;

  peripheral_ahb3_memtest_master_if #(.XLEN(XLEN), .PLEN(PLEN)) ahb ();

  peripheral_ahb3_memtest_master #(
    .XLEN(XLEN), .PLEN(PLEN), .BASE_ADDR(BASE), .NUM_WORDS(NW), .SEED(SEED)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .ahb(ahb)
  );

  always #5 HCLK = ~HCLK;

  int              waitCfg[NB];
  bit              errCfg[NB];
  bit              corruptCfg[NW];
  logic [XLEN-1:0] mem[NW];
  logic [XLEN-1:0] preMem[NW];
  logic [34:0]     beatLog[$];
  int              beatNo;
  int              holdErrs;
  int              total = 0;
  int              bad   = 0;

  function automatic logic [XLEN-1:0] pat(input int i);
    logic [31:0] w;
    w = SEED ^ (32'(i) * 32'h9E37_79B9);
    return {(XLEN/32){w}};
  endfunction

  function automatic logic [34:0] expBeat(input int b);
    int  idx;
    bit  wr;
    logic [1:0] tr;
    wr  = (b < NW);
    idx = wr ? b : b - NW;
    tr  = (idx == 0) ? 2'b10 : 2'b11;
    return {wr, tr, 32'(BASE + 64'(idx * STEP))};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clearCfg();
    for (int b = 0; b < NB; b++) begin
      waitCfg[b] = 0;
      errCfg[b]  = 1'b0;
    end
    for (int i = 0; i < NW; i++) corruptCfg[i] = 1'b0;
  endtask

  // RAM slave: decides the response for the current cycle at each falling edge.
  initial begin : slave
    bit              dpActive, dpWrite, dpErr, dpErrStage;
    int              dpIdx, dpWait;
    bit              prevValid, prevReady;
    logic [PLEN-1:0] prevAddr, off;
    logic [1:0]      prevTrans;
    logic            prevWrite;
    logic [XLEN-1:0] prevWdata;
    dpActive = 0; dpWrite = 0; dpErr = 0; dpErrStage = 0; dpIdx = 0; dpWait = 0;
    prevValid = 0; prevReady = 1; prevAddr = '0; prevTrans = '0; prevWrite = 0; prevWdata = '0;
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dpActive   = 0;
        prevValid  = 0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
      end else begin
        if (prevValid && !prevReady) begin
          if (ahb.HADDR !== prevAddr || ahb.HTRANS !== prevTrans || ahb.HWRITE !== prevWrite)
            holdErrs++;
          if (dpActive && dpWrite && ahb.HWDATA !== prevWdata) holdErrs++;
        end
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
        if (dpActive) begin
          if (dpErr) begin
            ahb.HRESP  = 1'b1;
            ahb.HREADY = dpErrStage;
            dpErrStage = 1'b1;
          end else if (dpWait > 0) begin
            ahb.HREADY = 1'b0;
            dpWait--;
          end else if (dpIdx >= 0) begin
            if (dpWrite) mem[dpIdx] = ahb.HWDATA;
            else         ahb.HRDATA = mem[dpIdx] ^ XLEN'(corruptCfg[dpIdx]);
          end
        end
        if (ahb.HREADY) begin
          dpActive = 0;
          if (ahb.HTRANS != 2'b00) begin
            beatLog.push_back({ahb.HWRITE, ahb.HTRANS, ahb.HADDR[31:0]});
            off        = ahb.HADDR - BASE;
            dpActive   = 1;
            dpWrite    = ahb.HWRITE;
            dpIdx      = (off < 64'(NW * STEP)) ? int'(off / 64'(STEP)) : -1;
            dpWait     = (beatNo < NB) ? waitCfg[beatNo] : 0;
            dpErr      = (beatNo < NB) ? errCfg[beatNo] : 1'b0;
            dpErrStage = 0;
            beatNo++;
          end
        end
        prevValid = 1;
        prevReady = ahb.HREADY;
        prevAddr  = ahb.HADDR;
        prevTrans = ahb.HTRANS;
        prevWrite = ahb.HWRITE;
        prevWdata = ahb.HWDATA;
      end
    end
  end

  task automatic applyStimulus(input bit preload, input int midStart,
                               output int doneCycle, output bit busyBefore);
    int n;
    beatLog.delete();
    beatNo     = 0;
    holdErrs   = 0;
    busyBefore = 0;
    for (int i = 0; i < NW; i++) begin
      if (preload) mem[i] = ~pat(i);
      preMem[i] = mem[i];
    end
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    n = 1;
    while (!done && n < 2000) begin
      busyBefore = busy;
      start = (n == midStart);
      @(negedge HCLK);
      n++;
    end
    start = 1'b0;
    doneCycle = done ? n : -1;
  endtask

  // Reference: ERRORs count once each; an unerrored read mismatches when the stored word
  // (pattern, or the prior contents if its write errored) differs from the pattern.
  task automatic checkRun(input string tag);
    int              expErr;
    logic [XLEN-1:0] rd;
    expErr = 0;
    for (int b = 0; b < NB; b++) if (errCfg[b]) expErr++;
    for (int i = 0; i < NW; i++) begin
      if (!errCfg[NW + i]) begin
        rd = errCfg[i] ? preMem[i] : pat(i);
        if (corruptCfg[i]) rd[0] = ~rd[0];
        if (rd != pat(i)) expErr++;
      end
    end
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".errCnt"}, err_cnt, expErr);
    checkOutput({tag, ".pass"}, pass, (expErr == 0));
    checkOutput({tag, ".hold"}, holdErrs, 0);
    checkOutput({tag, ".beats"}, beatLog.size(), NB);
    for (int b = 0; b < NB && b < beatLog.size(); b++)
      checkOutput($sformatf("%s.beat%0d", tag, b), beatLog[b], expBeat(b));
    for (int i = 0; i < NW; i++)
      if (!errCfg[i]) checkOutput($sformatf("%s.mem%0d", tag, i), mem[i], pat(i));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int dc, busySeen;
    bit bb;
    clearCfg();
    for (int i = 0; i < NW; i++) mem[i] = '0;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.pass", pass, 0);
    checkOutput("rst.errCnt", err_cnt, 0);
    checkOutput("rst.htrans", ahb.HTRANS, 0);
    checkOutput("rst.hsel", ahb.HSEL, 0);
    checkOutput("rst.hwrite", ahb.HWRITE, 0);
    checkOutput("rst.haddr", ahb.HADDR, BASE);
    checkOutput("rst.hwdata", ahb.HWDATA, 0);
    checkOutput("rst.hburst", ahb.HBURST, 3'b001);
    checkOutput("rst.hsize", ahb.HSIZE, 3'b011);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    checkOutput("idle.htrans", ahb.HTRANS, 0);
    checkOutput("idle.done", done, 0);

    clearCfg();
    applyStimulus(1, -1, dc, bb);
    checkOutput("pass.doneCycle", dc, 11);
    checkOutput("pass.busyBeforeDone", bb, 1);
    checkRun("pass");

    clearCfg();
    for (int b = 0; b < NB; b++) waitCfg[b] = 2;
    applyStimulus(1, -1, dc, bb);
    checkRun("wait");

    clearCfg();
    corruptCfg[2] = 1'b1;
    applyStimulus(1, -1, dc, bb);
    checkRun("corrupt");

    clearCfg();
    errCfg[1] = 1'b1;
    applyStimulus(0, -1, dc, bb);
`ifdef PERIPHERAL_AHB3_MEMTEST_STOP_ON_ERROR_EN
    checkOutput("err.done", done, 1);
    checkOutput("err.errCnt", err_cnt, 1);
    checkOutput("err.pass", pass, 0);
    checkOutput("err.beats", beatLog.size(), 3);
    for (int b = 0; b < 3 && b < beatLog.size(); b++)
      checkOutput($sformatf("err.beat%0d", b), beatLog[b], expBeat(b));
`else
    checkRun("err");
`endif

    clearCfg();
    applyStimulus(1, 7, dc, bb);
    checkOutput("busyStart.doneCycle", dc, 11);
    checkRun("busyStart");
    busySeen = 0;
    repeat (6) begin
      @(negedge HCLK);
      if (busy || !done) busySeen++;
    end
    checkOutput("busyStart.noRestart", busySeen, 0);

    clearCfg();
    for (int i = 0; i < NW; i++) mem[i] = ~pat(i);
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (2) @(negedge HCLK);
    checkOutput("rstMid.haddr", ahb.HADDR, BASE + 64'(2 * STEP));
    HRESETn = 1'b0;
    #1;
    checkOutput("rstMid.htrans", ahb.HTRANS, 0);
    checkOutput("rstMid.hsel", ahb.HSEL, 0);
    checkOutput("rstMid.busy", busy, 0);
    checkOutput("rstMid.errCnt", err_cnt, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    applyStimulus(1, -1, dc, bb);
    checkRun("rstMid");

    for (int r = 0; r < 6; r++) begin
      clearCfg();
      for (int b = 0; b < NB; b++) waitCfg[b] = $urandom_range(0, 3);
`ifndef PERIPHERAL_AHB3_MEMTEST_STOP_ON_ERROR_EN
      for (int b = 0; b < NB; b++) errCfg[b] = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NW; i++) corruptCfg[i] = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(bit'($urandom_range(0, 1)), -1, dc, bb);
      checkRun($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
